// File: rtl/systolic_block_accumulator.sv
// Accumulates CHUNK_SIZE-element partial-product beats over STEPS beats and emits one finished block.
// Optional output clamping is enabled by defining ACC_SATURATE_EN; otherwise sums wrap to WIDTH bits.
module systolic_block_accumulator #(
  parameter int WIDTH           = 16,
  parameter int FRAC_WIDTH      = 8,
  parameter int BLOCK_SIZE      = 2,
  parameter int CHUNK_SIZE      = BLOCK_SIZE * BLOCK_SIZE,
  parameter int INNER_DIMENSION = 64
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clear,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [WIDTH*CHUNK_SIZE-1:0]               in,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [WIDTH*CHUNK_SIZE-1:0]               out,
  output logic                                      out_sat,
  output logic [$clog2(INNER_DIMENSION/BLOCK_SIZE+1)-1:0] beat_cnt
);

  localparam int STEPS     = INNER_DIMENSION / BLOCK_SIZE;
  localparam int ACC_WIDTH = WIDTH + $clog2(STEPS) + 1;
  localparam int CNT_WIDTH = $clog2(STEPS + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(STEPS - 1);

  // Fixed-point position is untouched by summation, so FRAC_WIDTH only needs to be sane.
  if (STEPS < 1 || (INNER_DIMENSION % BLOCK_SIZE) != 0 || FRAC_WIDTH < 0 || FRAC_WIDTH > WIDTH)
  begin : g_bad_params
    $error("systolic_block_accumulator: illegal parameter combination");
  end

  logic signed [ACC_WIDTH-1:0] acc [CHUNK_SIZE];
  logic signed [ACC_WIDTH-1:0] sum [CHUNK_SIZE];
  logic [WIDTH*CHUNK_SIZE-1:0] out_next;
  logic                        out_sat_next;
  logic                        last_beat;
  logic                        accept;
  logic                        load_out;

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign in_ready  = !(last_beat && out_valid && !out_ready);
  assign accept    = in_valid && in_ready && !clear;
  assign load_out  = accept && last_beat;

`ifdef ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  logic [CHUNK_SIZE-1:0] clamped;
  assign out_sat_next = |clamped;
`else
  assign out_sat_next = 1'b0;
`endif

  for (genvar k = 0; k < CHUNK_SIZE; k++) begin : g_elem
    logic [WIDTH-1:0] elem;
    assign elem   = in[WIDTH*CHUNK_SIZE-1-WIDTH*k -: WIDTH];
    assign sum[k] = acc[k] + $signed({{(ACC_WIDTH-WIDTH){elem[WIDTH-1]}}, elem});
`ifdef ACC_SATURATE_EN
    logic [WIDTH-1:0] reduced;
    always_comb begin
      reduced    = sum[k][WIDTH-1:0];
      clamped[k] = 1'b0;
      if (sum[k] > SAT_MAX) begin
        reduced    = SAT_MAX[WIDTH-1:0];
        clamped[k] = 1'b1;
      end else if (sum[k] < SAT_MIN) begin
        reduced    = SAT_MIN[WIDTH-1:0];
        clamped[k] = 1'b1;
      end
    end
    assign out_next[WIDTH*CHUNK_SIZE-1-WIDTH*k -: WIDTH] = reduced;
`else
    assign out_next[WIDTH*CHUNK_SIZE-1-WIDTH*k -: WIDTH] = sum[k][WIDTH-1:0];
`endif
  end

  // The last beat restarts accumulation from zero on the same edge, so blocks run back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHUNK_SIZE; k++) acc[k] <= '0;
      beat_cnt <= '0;
    end else if (clear) begin
      for (int k = 0; k < CHUNK_SIZE; k++) acc[k] <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      if (last_beat) begin
        for (int k = 0; k < CHUNK_SIZE; k++) acc[k] <= '0;
        beat_cnt <= '0;
      end else begin
        for (int k = 0; k < CHUNK_SIZE; k++) acc[k] <= sum[k];
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else if (load_out) begin
      out       <= out_next;
      out_valid <= 1'b1;
      out_sat   <= out_sat_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_block_accumulator.sv
// Randomized and directed bench for systolic_block_accumulator (default parameters, 4 elements x 16 bits, 32 beats).
module tb_systolic_block_accumulator;

  localparam int STEPS = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out;
  logic        out_sat;
  logic [5:0]  beat_cnt;

  int total = 0;
  int bad = 0;

  // Block-level reference: integer sums plus a beat count and the pending output slot.
  longint      m_acc [4];
  int          m_cnt;
  logic        m_ov;
  logic [63:0] m_out;
  logic        m_sat;
  logic        last_acc;

  systolic_block_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_sat(out_sat), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] splat(input logic [15:0] e);
    return {e, e, e, e};
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 4; k++) m_acc[k] = 0;
    m_cnt = 0;
    m_ov  = 1'b0;
    m_out = '0;
    m_sat = 1'b0;
  endtask

  task automatic modelStep(input logic v, input logic [63:0] data, input logic ordy, input logic clr);
    logic rdy;
    logic take;
    logic done;
    longint s;
    logic [15:0] r;
    rdy  = !(m_cnt == STEPS - 1 && m_ov && !ordy);
    take = v && rdy && !clr;
    done = 1'b0;
    last_acc = take;
    if (clr) begin
      for (int k = 0; k < 4; k++) m_acc[k] = 0;
      m_cnt = 0;
    end else if (take) begin
      for (int k = 0; k < 4; k++) m_acc[k] += longint'($signed(data[63-16*k -: 16]));
      if (m_cnt == STEPS - 1) begin
        m_sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
          s = m_acc[k];
          r = s[15:0];
`ifdef ACC_SATURATE_EN
          if (s > 32767) begin r = 16'h7FFF; m_sat = 1'b1; end
          else if (s < -32768) begin r = 16'h8000; m_sat = 1'b1; end
`endif
          m_out[63-16*k -: 16] = r;
          m_acc[k] = 0;
        end
        m_cnt = 0;
        done  = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    if (done) m_ov = 1'b1;
    else if (ordy) m_ov = 1'b0;
  endtask

  // One clock: drive on the falling edge, compare against the model, then advance the model on the rising edge.
  task automatic applyStimulus(input logic v, input logic [63:0] data, input logic ordy, input logic clr);
    @(negedge clk);
    in_valid  = v;
    in        = data;
    out_ready = ordy;
    clear     = clr;
    #1;
    checkOutput("in_ready", {63'd0, in_ready}, {63'd0, !(m_cnt == STEPS - 1 && m_ov && !ordy)});
    checkOutput("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
    checkOutput("beat_cnt", {58'd0, beat_cnt}, 64'(m_cnt));
    if (m_ov) begin
      checkOutput("out", out, m_out);
      checkOutput("out_sat", {63'd0, out_sat}, {63'd0, m_sat});
    end
    @(posedge clk);
    modelStep(v, data, ordy, clr);
  endtask

  task automatic sendBeats(input int n, input logic [63:0] data, input logic ordy);
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 4; t++) begin
        applyStimulus(1'b1, data, ordy, 1'b0);
        if (last_acc) break;
      end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    modelReset();
    last_acc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then 32 beats of 1.0 give 32.0.
    idle();
    sendBeats(STEPS, splat(16'h0100), 1'b1);
    #2;
    checkOutput("blk1_out", out, splat(16'h2000));
    checkOutput("blk1_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("blk1_sat", {63'd0, out_sat}, 64'd0);
    idle();

    // Back-to-back blocks with no gap.
    sendBeats(STEPS, 64'h0010_0020_0030_0040, 1'b1);
    #2;
    checkOutput("blkA_out", out, 64'h0200_0400_0600_0800);
    sendBeats(STEPS, splat(16'hFFF0), 1'b1);
    #2;
    checkOutput("blkB_out", out, splat(16'hFE00));
    idle();

    // Backpressure: the last beat of B stalls until A is taken.
    sendBeats(STEPS, 64'h0010_0020_0030_0040, 1'b0);
    sendBeats(STEPS - 1, splat(16'hFFF0), 1'b0);
    repeat (3) begin
      applyStimulus(1'b1, splat(16'hFFF0), 1'b0, 1'b0);
      #2;
      checkOutput("stall_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("stall_hold", out, 64'h0200_0400_0600_0800);
    end
    applyStimulus(1'b1, splat(16'hFFF0), 1'b1, 1'b0);
    #2;
    checkOutput("release_out", out, splat(16'hFE00));
    checkOutput("release_valid", {63'd0, out_valid}, 64'd1);
    idle();

    // Overflow of 32 x 0x7000.
    sendBeats(STEPS, splat(16'h7000), 1'b1);
    #2;
`ifdef ACC_SATURATE_EN
    checkOutput("ovf_out", out, splat(16'h7FFF));
    checkOutput("ovf_sat", {63'd0, out_sat}, 64'd1);
`else
    checkOutput("ovf_out", out, splat(16'h0000));
    checkOutput("ovf_sat", {63'd0, out_sat}, 64'd0);
`endif
    idle();

    // clear discards a partial block and the beat offered with it.
    sendBeats(10, splat(16'h0100), 1'b1);
    applyStimulus(1'b1, splat(16'h0100), 1'b1, 1'b1);
    #2;
    checkOutput("clear_cnt", {58'd0, beat_cnt}, 64'd0);
    sendBeats(STEPS, splat(16'h0001), 1'b1);
    #2;
    checkOutput("clear_out", out, splat(16'h0020));

    // Asynchronous reset mid-block while a result is pending.
    sendBeats(17, splat(16'h0100), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("arst_out", out, 64'd0);
    checkOutput("arst_cnt", {58'd0, beat_cnt}, 64'd0);
    checkOutput("arst_ready", {63'd0, in_ready}, 64'd1);
    modelReset();
    #1 rst_n = 1'b1;
    @(posedge clk);
    modelStep(1'b0, '0, out_ready, 1'b0);
    sendBeats(STEPS, splat(16'h0100), 1'b1);
    #2;
    checkOutput("post_rst_out", out, splat(16'h2000));

    // Random traffic with random backpressure and rare clears.
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    {$urandom, $urandom},
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 149) == 0);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_block_accumulator.md
# systolic_block_accumulator

- Accumulates partial-product blocks from the N×N systolic array over the inner dimension and emits one finished output block per INNER_DIMENSION/BLOCK_SIZE accepted input beats.
- Parametrised in element width, block size and inner dimension.
- Clocked valid/ready handshakes on both sides, with a one-entry output register so the next block accumulates while the previous one drains.
- Signed accumulation with guard bits; optional saturation on output.

## Interface
- WIDTH, 16, signed fixed-point element width.
- FRAC_WIDTH, 8, fractional bits; carried through unchanged because sums need no rescale.
- BLOCK_SIZE, 2, systolic array dimension N.
- CHUNK_SIZE, BLOCK_SIZE*BLOCK_SIZE, elements per beat.
- INNER_DIMENSION, 64, shared inner dimension; must be a multiple of BLOCK_SIZE.
- STEPS (localparam), INNER_DIMENSION/BLOCK_SIZE, beats per output block; STEPS ≥ 1.
- ACC_WIDTH (localparam), WIDTH+$clog2(STEPS)+1, internal accumulator width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort: discards the partial block and zeroes the beat counter.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in  in  WIDTH*CHUNK_SIZE  element 0 in the MSBs: element k = in[W*C-1-W*k -: WIDTH].
- out_valid  out  1  finished block held in out.
- out_ready  in  1  consumer accepts out.
- out  out  WIDTH*CHUNK_SIZE  finished block, same element order as in.
- out_sat  out  1  at least one element of out was clamped.
- beat_cnt  out  $clog2(STEPS+1)  beats accumulated into the current block.

## Operation
- Per-element accumulators acc[0..CHUNK_SIZE-1] hold ACC_WIDTH signed values. Each input element is sign-extended before the add.
- On an accepted beat with beat_cnt < STEPS-1:
  - acc[k] += in element k;
  - beat_cnt increments.
- On an accepted beat with beat_cnt == STEPS-1 (last beat):
  - the result acc[k] + element k is reduced to WIDTH bits (see Configuration) and loaded into out;
  - out_valid is set;
  - all acc[k] and beat_cnt go to 0 in the same edge, so the next block starts on the next beat with no bubble.
- in_ready = !(beat_cnt == STEPS-1 && out_valid && !out_ready).
  - Input stalls only when a last beat would overwrite an undrained output.
  - This is a combinational path from out_ready to in_ready.
- Output acceptance:
  - out_valid && out_ready with no new last beat: out_valid clears.
  - The same cycle as a new last beat: out reloads and out_valid stays 1.
- out and out_sat are stable while out_valid && !out_ready.
- clear:
  - zeroes acc and beat_cnt; any beat offered that cycle is dropped;
  - does not affect out, out_valid or out_sat;
  - clear takes priority over in_valid.
- STEPS == 1: every accepted beat is a last beat, and out is the reduced input.

## Timing
- Reset values: in_ready 1, out_valid 0, out all-zero, out_sat 0, beat_cnt 0, acc all-zero.
- Reset asserted mid-block or with out_valid high: everything returns to reset values immediately, and the partial block and pending output are lost.
- Latency: out_valid rises on the clock edge that accepts the last beat, and is visible the following cycle.
- Throughput: one beat per cycle sustained when out_ready is held high, giving one block per STEPS cycles.
- beat_cnt never reaches STEPS; it wraps STEPS-1 → 0 on the last beat.

## Configuration
- ACC_SATURATE_EN defined:
  - each element of the final sum is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1];
  - out_sat is the OR of the per-element clamp events for that block.
- ACC_SATURATE_EN undefined:
  - out takes the low WIDTH bits of each sum (two's-complement wrap);
  - out_sat is tied to 0.

## Test plan
- Reset, WIDTH=16, STEPS=32; send 32 beats of every element = 16'h0100 (1.0) with out_ready=1 → out_valid pulses after beat 32, every element 16'h2000, out_sat=0, in_ready never low.
- Back-to-back blocks: block A elements {1,2,3,4}·0x0010 and block B elements all 0xFFF0 (-0x10), 32 beats each, no gaps → A = {0x0200,0x0400,0x0600,0x0800}, B = 0xFE00 each, no bubble between blocks.
- Backpressure: out_ready=0 after block A completes; feed block B → in_ready drops only when B's beat 31 is offered; out holds A; raising out_ready takes A and accepts the stalled beat the same cycle.
- Overflow: 32 beats of 16'h7000 → with ACC_SATURATE_EN, elements 16'h7FFF and out_sat=1; without it, elements 16'h0000 (low 16 bits of 0xE0000) and out_sat=0.
- clear after 10 beats of 0x0100, then 32 beats of 0x0001 → out elements 16'h0020; beat_cnt reads 0 on the cycle after clear.
- rst_n pulsed low asynchronously (between edges) at beat 17 with out_valid=1 → out_valid and out zero immediately; the next full block accumulates from 0.
